// File: rtl/somador_serial.sv
// somador_serial: multi-cycle adder/subtractor that processes CHUNK bits per clock
// through a registered ripple carry. It uses an inicio/pronto handshake and reports
// carry, signed overflow and zero.
//
// Parameters:
//   WIDTH  operand and result width
//   CHUNK  bits added per clock; must divide WIDTH (CHUNK == WIDTH -> 1 cycle)
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   inicio     start request, sampled on a rising edge while idle
//   subtrai    0: valor1 + valor2, 1: valor1 - valor2 (sampled with inicio)
//   valor1     operand A (sampled with inicio)
//   valor2     operand B (sampled with inicio)
//   soma       registered result; updated only on completion
//   carry_out  carry out of the MSB (subtraction: 1 = no borrow)
//   overflow   two's-complement signed overflow
//   zero       soma == 0
//   ocupado    operation in progress
//   pronto     one-cycle pulse when soma and the flags have been updated
module somador_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inicio,
  input  logic             subtrai,
  input  logic [WIDTH-1:0] valor1,
  input  logic [WIDTH-1:0] valor2,
  output logic [WIDTH-1:0] soma,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             ocupado,
  output logic             pronto
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("somador_serial: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
  end

  typedef enum logic {
    Ocioso,
    Calcula
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // Latched operands. r_b already holds ~valor2 for subtraction.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] r_soma;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_zero;
  logic             r_pronto;

  logic             w_accept;
  logic             w_step;
  logic             w_last;

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_add;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;

  // Chunk datapath. The accumulator holds zeros above the current chunk, so OR-ing
  // in the shifted chunk sum yields the full result on the last step.
  always_comb begin
    w_base      = 32'(r_k) * CHUNK;
    w_a_chunk   = CHUNK'(r_a >> w_base);
    w_b_chunk   = CHUNK'(r_b >> w_base);
    w_chunk_add = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_sum       = w_chunk_add[CHUNK-1:0];
    w_cout      = w_chunk_add[CHUNK];
    w_result    = r_acc | (WIDTH'(w_sum) << w_base);
    // Operands of equal sign that yield a result of the other sign.
    w_overflow  = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_result[WIDTH-1] != r_a[WIDTH-1]);
  end

  // Next-state and control decode.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      Ocioso: begin
        if (inicio) begin
          w_accept     = 1'b1;
          w_state_next = Calcula;
        end
      end
      Calcula: begin
        w_step = 1'b1;
        if (r_k == CW'(N - 1)) begin
          w_last       = 1'b1;
          w_state_next = Ocioso;
        end
      end
      default: w_state_next = Ocioso;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= Ocioso;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_acc       <= '0;
      r_soma      <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b1;
      r_pronto    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pronto <= w_last;

      if (w_accept) begin
        r_a     <= valor1;
        r_b     <= subtrai ? ~valor2 : valor2;
        // Carry-in of 1 completes the two's complement of valor2.
        r_carry <= subtrai;
        r_k     <= '0;
        r_acc   <= '0;
      end

      if (w_step) begin
        r_acc   <= w_result;
        r_carry <= w_cout;
        r_k     <= r_k + 1'b1;
      end

      // Visible outputs change only here, so partial sums never leak out.
      if (w_last) begin
        r_soma      <= w_result;
        r_carry_out <= w_cout;
        r_overflow  <= w_overflow;
        r_zero      <= (w_result == '0);
      end
    end
  end

  assign soma      = r_soma;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign ocupado   = (r_state == Calcula);
  assign pronto    = r_pronto;

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial: directed cases on a 32/8 instance, plus a
// randomized sweep over four WIDTH/CHUNK configurations against an arithmetic model.
module tb_somador_serial;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  logic clock;
  logic rst_n;
  logic rst_dir_n;
  int   n_checks;
  int   n_pass;
  int   n_rand_done;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference result from plain integer arithmetic on w-bit operands.
  function automatic res_t ref_calc(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic sub);
    res_t   r;
    longint mask, half, ua, ub, sa, sb, full, exact;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (!sub) begin
      full = ua + ub;
      r.s  = 32'(full & mask);
      r.c  = (full > mask);
    end else begin
      r.s  = 32'((ua - ub) & mask);
      r.c  = (ua >= ub);
    end
    sa    = (ua >= half) ? ua - 2 * half : ua;
    sb    = (ub >= half) ? ub - 2 * half : ub;
    exact = sub ? sa - sb : sa + sb;
    r.v   = (exact >= half) || (exact < -half);
    r.z   = (r.s == 32'd0);
    return r;
  endfunction

  // ---------------------------------------------------------------- directed DUT
  logic        d_inicio, d_sub;
  logic [31:0] d_v1, d_v2, d_soma;
  logic        d_c, d_v, d_z, d_oc, d_pr;

  somador_serial #(.WIDTH(32), .CHUNK(8)) u_dir (
    .clock     (clock),
    .reset_n   (rst_dir_n),
    .inicio    (d_inicio),
    .subtrai   (d_sub),
    .valor1    (d_v1),
    .valor2    (d_v2),
    .soma      (d_soma),
    .carry_out (d_c),
    .overflow  (d_v),
    .zero      (d_z),
    .ocupado   (d_oc),
    .pronto    (d_pr)
  );

  task automatic run_dir(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] es, input logic ec,
                         input logic ev, input logic ez);
    int   k;
    res_t r;
    r = ref_calc(32, a, b, sub);
    check({name, " model s"}, r.s, es);
    check({name, " model c"}, r.c, ec);
    check({name, " model v"}, r.v, ev);
    check({name, " model z"}, r.z, ez);
    @(negedge clock);
    d_inicio = 1'b1; d_sub = sub; d_v1 = a; d_v2 = b;
    @(negedge clock);
    // Accepted on the edge just passed; scramble inputs to prove they are ignored.
    d_inicio = 1'b0; d_sub = ~sub; d_v1 = ~a; d_v2 = ~b;
    check({name, " ocupado"}, d_oc, 1'b1);
    k = 0;
    while (!d_pr && k < 20) begin
      @(negedge clock);
      k++;
    end
    check({name, " latency"}, k, 4);
    check({name, " soma"}, d_soma, es);
    check({name, " carry"}, d_c, ec);
    check({name, " ovf"}, d_v, ev);
    check({name, " zero"}, d_z, ez);
  endtask

  // ---------------------------------------------------------------- random sweep
  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int W = (g == 3) ? 16 : 32;
    localparam int C = (g == 0) ? 8 : (g == 1) ? 32 : (g == 2) ? 1 : 4;
    localparam int N = W / C;

    logic         inicio, subtrai;
    logic [W-1:0] v1, v2, soma;
    logic         co, ov, z, oc, pr;

    somador_serial #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clock     (clock),
      .reset_n   (rst_n),
      .inicio    (inicio),
      .subtrai   (subtrai),
      .valor1    (v1),
      .valor2    (v2),
      .soma      (soma),
      .carry_out (co),
      .overflow  (ov),
      .zero      (z),
      .ocupado   (oc),
      .pronto    (pr)
    );

    res_t         w_ref;
    int           m_left, m_done;
    logic [W-1:0] p_soma, m_soma;
    logic         p_c, p_v, p_z, m_c, m_v, m_z, m_pronto;

    assign w_ref = ref_calc(W, 32'(v1), 32'(v2), subtrai);

    // Model: an accepted request completes N edges later; outputs hold otherwise.
    always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        m_left <= 0; m_done <= 0; m_pronto <= 1'b0;
        m_soma <= '0; m_c <= 1'b0; m_v <= 1'b0; m_z <= 1'b1;
      end else begin
        m_pronto <= 1'b0;
        if (m_left > 0) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_pronto <= 1'b1;
            m_soma   <= p_soma; m_c <= p_c; m_v <= p_v; m_z <= p_z;
            m_done   <= m_done + 1;
          end
        end else if (inicio) begin
          m_left <= N;
          p_soma <= w_ref.s[W-1:0]; p_c <= w_ref.c; p_v <= w_ref.v; p_z <= w_ref.z;
        end
      end
    end

    always @(negedge clock) begin
      if (rst_n === 1'b1) begin
        check($sformatf("cfg%0d soma", g), soma, m_soma);
        check($sformatf("cfg%0d carry", g), co, m_c);
        check($sformatf("cfg%0d ovf", g), ov, m_v);
        check($sformatf("cfg%0d zero", g), z, m_z);
        check($sformatf("cfg%0d ocupado", g), oc, (m_left > 0));
        check($sformatf("cfg%0d pronto", g), pr, m_pronto);
      end
    end

    function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 7))
        0:       return '0;
        1:       return '1;
        2:       return {1'b1, {(W-1){1'b0}}};
        3:       return {1'b0, {(W-1){1'b1}}};
        4:       return W'(1);
        default: return W'($urandom);
      endcase
    endfunction

    initial begin
      inicio = 1'b0; subtrai = 1'b0; v1 = '0; v2 = '0;
      wait (rst_n === 1'b1);
      for (int cyc = 0; cyc < 60000 && m_done < 1000; cyc++) begin
        @(negedge clock);
        inicio  = ($urandom_range(0, 3) != 0);
        subtrai = 1'($urandom_range(0, 1));
        v1      = rand_op();
        v2      = rand_op();
      end
      inicio = 1'b0;
      check($sformatf("cfg%0d ops done", g), (m_done >= 1000), 1'b1);
      repeat (N + 3) @(negedge clock);
      n_rand_done++;
    end
  end

  // ---------------------------------------------------------------- main sequence
  initial begin
    int  j;
    bit  saw_pronto;
    n_checks = 0; n_pass = 0; n_rand_done = 0;
    rst_n = 1'b0; rst_dir_n = 1'b0;
    d_inicio = 1'b0; d_sub = 1'b0; d_v1 = '0; d_v2 = '0;

    // Model pinned on a 16-bit case as well.
    begin
      res_t r16;
      r16 = ref_calc(16, 32'h7FFF, 32'h0001, 1'b0);
      check("model16 s", r16.s, 32'h8000);
      check("model16 v", r16.v, 1'b1);
      check("model16 c", r16.c, 1'b0);
    end

    repeat (3) @(negedge clock);
    check("rst soma", d_soma, 32'h0);
    check("rst carry", d_c, 1'b0);
    check("rst ovf", d_v, 1'b0);
    check("rst zero", d_z, 1'b1);
    check("rst ocupado", d_oc, 1'b0);
    check("rst pronto", d_pr, 1'b0);
    rst_n = 1'b1; rst_dir_n = 1'b1;

    run_dir("add", 32'h0000_0004, 32'h0040_0000, 1'b0, 32'h0040_0004, 1'b0, 1'b0, 1'b0);
    run_dir("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_dir("ovfadd", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_dir("ovfsub", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_dir("borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // Handshake: inicio held high, operands changed mid-flight, re-accept on pronto.
    @(negedge clock);
    d_inicio = 1'b1; d_sub = 1'b0; d_v1 = 32'h1234_5678; d_v2 = 32'h1111_1111;
    @(negedge clock);
    d_v1 = 32'h0000_0100; d_v2 = 32'h0000_0023;
    j = 0;
    while (!d_pr && j < 20) begin
      @(negedge clock);
      j++;
    end
    check("hs first latency", j, 4);
    check("hs first soma", d_soma, 32'h2345_6789);
    j = 0;
    do begin
      @(negedge clock);
      j++;
    end while (!d_pr && j < 20);
    d_inicio = 1'b0;
    check("hs back-to-back gap", j, 5);
    check("hs second soma", d_soma, 32'h0000_0123);

    // Reset in the middle of an operation.
    @(negedge clock);
    d_inicio = 1'b1; d_sub = 1'b1; d_v1 = 32'h0000_0009; d_v2 = 32'h0000_0002;
    @(negedge clock);
    d_inicio = 1'b0;
    @(negedge clock);
    check("midrst ocupado before", d_oc, 1'b1);
    #2 rst_dir_n = 1'b0;
    #1;
    check("midrst soma", d_soma, 32'h0);
    check("midrst carry", d_c, 1'b0);
    check("midrst ovf", d_v, 1'b0);
    check("midrst zero", d_z, 1'b1);
    check("midrst ocupado", d_oc, 1'b0);
    check("midrst pronto", d_pr, 1'b0);
    @(negedge clock);
    rst_dir_n = 1'b1;
    saw_pronto = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (d_pr) saw_pronto = 1'b1;
    end
    check("midrst no pronto", saw_pronto, 1'b0);
    run_dir("after rst", 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 80000 && n_rand_done < 4; i++) @(negedge clock);
    check("random sweep finished", n_rand_done, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/somador_serial.md
Name: somador_serial

Overview:
- Parametrised multi-cycle adder/subtractor, successor of the combinational 32-bit adder in the MIPS datapath.
- Processes operands CHUNK bits per clock with a registered ripple carry.
- Uses a start/ready handshake and produces carry, signed-overflow and zero flags.
- Targets PC/branch arithmetic and the future multi-cycle core, where a narrow adder reused over cycles is preferred.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per clock. Must divide WIDTH; elaboration error otherwise. CHUNK = WIDTH gives a 1-cycle operation.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- inicio  input  1  start request, sampled on a rising edge.
- subtrai  input  1  mode, sampled with inicio: 0 = valor1+valor2, 1 = valor1-valor2.
- valor1  input  WIDTH  operand A, sampled with inicio.
- valor2  input  WIDTH  operand B, sampled with inicio.
- soma  output  WIDTH  registered result.
- carry_out  output  1  carry out of the MSB. For subtraction, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  soma == 0.
- ocupado  output  1  operation in progress.
- pronto  output  1  one-cycle pulse: result and flags valid/updated.

Behaviour:
- Reset: reset_n low asynchronously forces state OCIOSO and clears soma, carry_out, overflow, ocupado, pronto and the chunk counter. zero resets to 1, consistent with soma = 0. Reset mid-operation aborts it; no pronto follows.
- N = WIDTH/CHUNK. Counter width is clog2(N), minimum 1.
- FSM with two states:
  - OCIOSO: ocupado = 0. If inicio = 1 at an edge, latch valor1; latch valor2, or ~valor2 if subtrai; set the internal carry to subtrai; clear the counter and accumulator; go to CALCULA; ocupado = 1.
  - CALCULA: each edge adds chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of A and B plus the stored carry, writes the chunk sum into the accumulator, stores the chunk carry, and increments k.
  - On the edge that processes chunk N-1: load soma, carry_out, overflow and zero from the full result; pulse pronto = 1 for exactly one cycle; set ocupado = 0; return to OCIOSO.
- Latency: inicio sampled at edge T → pronto high in the cycle after edge T+N. Example: WIDTH=32, CHUNK=8 gives 4 edges after acceptance.
- soma and the flags do not change during CALCULA. They hold their value between completions, so partial sums are never visible.
- overflow = (A[MSB] == B'[MSB]) && (soma[MSB] != A[MSB]), where B' is the inverted operand in subtract mode.
- Arithmetic is modulo 2^WIDTH; wrap-around is signalled only through carry_out and overflow.
- inicio while ocupado = 1 is ignored. No queueing, and in-flight operands are unaffected.
- inicio in the cycle pronto = 1: accepted, since the state is already OCIOSO. This allows back-to-back operations every N+1 edges.
- Input changes after acceptance have no effect on the current operation.

Test Plan:
- Reset mid-operation: pulse reset_n low while ocupado = 1 → outputs cleared immediately and asynchronously, zero = 1, no pronto; a new inicio afterwards completes normally.
- Add, WIDTH=32/CHUNK=8: valor1=0x0000_0004, valor2=0x0040_0000, subtrai=0 → pronto 4 edges after acceptance; soma=0x0040_0004; carry_out=0, overflow=0, zero=0.
- Carry and wrap: 0xFFFF_FFFF + 0x0000_0001 → soma=0, carry_out=1, overflow=0, zero=1. Checks carry ripple across all 4 chunks.
- Signed overflow: 0x7FFF_FFFF + 1 → soma=0x8000_0000, overflow=1, carry_out=0. Subtract 0x8000_0000 - 1 → soma=0x7FFF_FFFF, overflow=1, carry_out=1. Subtract 5 - 7 → soma=0xFFFF_FFFE, carry_out=0 (borrow).
- Handshake: hold inicio high and change operands during CALCULA → result reflects the first operands only. Assert inicio in the pronto cycle → second result 4 edges later, with no bubble beyond N+1.
- Parameter sweep: CHUNK=32 (1 cycle), CHUNK=1 (32 cycles), WIDTH=16/CHUNK=4 → 1000 random operand pairs per configuration match a reference model: result and all flags.
